// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and memory-side bus bundle for the sprite-RAM DMA sequencer.
// The DMA block is the master of the memory side. The slave view is the one the CPU/memory environment sees.
interface oam_dma_ctrl_if;
  logic [15:0] cpu_addr_out;
  logic [7:0]  cpu_data_out;
  logic        cpu_wen;
  logic        cpu_ren;
  logic        cpu_rdy;
  logic        dma_busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wen;
  logic        mem_ren;
  logic [7:0]  mem_rdata;

  modport master (
    input  cpu_addr_out, cpu_data_out, cpu_wen, cpu_ren, mem_rdata,
    output cpu_rdy, dma_busy, mem_addr, mem_wdata, mem_wen, mem_ren
  );

  modport slave (
    output cpu_addr_out, cpu_data_out, cpu_wen, cpu_ren, mem_rdata,
    input  cpu_rdy, dma_busy, mem_addr, mem_wdata, mem_wen, mem_ren
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite-RAM DMA sequencer: a CPU write to the DMA register stalls the CPU.
// It then copies one 256-byte page into the SPR-RAM data register, one read/write pair per byte.
//
// state | meaning
// IDLE  | CPU owns the bus, mem_* follow cpu_*
// HALT  | first stall cycle, bus idle
// ALIGN | extra idle cycle so READ lands on an even cycle
// READ  | fetch {page, idx} into data register
// WRITE | store data register to OAM_DATA_ADDR, advance idx
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input logic             clk,
  input logic             b_rst,
  oam_dma_ctrl_if.master  bus
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        parity_q, parity_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic [7:0]  dma_wdata_q, dma_wdata_d;
  logic        dma_wen_q, dma_wen_d;
  logic        dma_ren_q, dma_ren_d;

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    data_d   = data_q;
    parity_d = ~parity_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_wen && bus.cpu_addr_out == DMA_REG_ADDR) begin
          page_d  = bus.cpu_data_out;
          idx_d   = 8'd0;
          state_d = HALT;
        end
      end
      HALT:  state_d = parity_q ? READ : ALIGN;
      ALIGN: state_d = READ;
      READ: begin
        data_d  = bus.mem_rdata;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == LAST_IDX) ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered, so they are derived from the next state.
    rdy_d       = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    dma_ren_d   = (state_d == READ);
    dma_wen_d   = (state_d == WRITE);
    dma_wdata_d = (state_d == WRITE) ? data_d : 8'd0;
    if (state_d == READ)
      dma_addr_d = {page_d, idx_d};
    else if (state_d == WRITE)
      dma_addr_d = OAM_DATA_ADDR;
    else
      dma_addr_d = 16'd0;
  end

  always_ff @(posedge clk) begin
    if (!b_rst) begin
      state_q     <= IDLE;
      page_q      <= 8'd0;
      idx_q       <= 8'd0;
      data_q      <= 8'd0;
      parity_q    <= 1'b0;
      rdy_q       <= 1'b1;
      busy_q      <= 1'b0;
      dma_addr_q  <= 16'd0;
      dma_wdata_q <= 8'd0;
      dma_wen_q   <= 1'b0;
      dma_ren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      parity_q    <= parity_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
      dma_addr_q  <= dma_addr_d;
      dma_wdata_q <= dma_wdata_d;
      dma_wen_q   <= dma_wen_d;
      dma_ren_q   <= dma_ren_d;
    end
  end

  assign bus.cpu_rdy   = rdy_q;
  assign bus.dma_busy  = busy_q;
  assign bus.mem_addr  = busy_q ? dma_addr_q  : bus.cpu_addr_out;
  assign bus.mem_wdata = busy_q ? dma_wdata_q : bus.cpu_data_out;
  assign bus.mem_wen   = busy_q ? dma_wen_q   : bus.cpu_wen;
  assign bus.mem_ren   = busy_q ? dma_ren_q   : bus.cpu_ren;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: idle pass-through vectors, directed DMA transfers, and randomized transfers.
// The transfers are checked against a page-copy model backed by a 64 KiB memory array.
module tb_oam_dma_ctrl;

  logic clk;
  logic b_rst;
  oam_dma_ctrl_if bus();

  oam_dma_ctrl dut (
    .clk   (clk),
    .b_rst (b_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram [0:65535];
  assign bus.mem_rdata = ram[bus.mem_addr];

  int total = 0;
  int bad   = 0;

  int          cnt = 0;
  int          stall_cnt, par_bad, stray, idle_busy;
  logic [7:0]  wlog [$];
  logic [15:0] rlog [$];

  // Memory map model plus bus observer; $2004 is a port, not storage.
  always @(posedge clk) begin
    if (bus.mem_wen && bus.mem_addr != 16'h2004) ram[bus.mem_addr] = bus.mem_wdata;
    if (!bus.cpu_rdy) stall_cnt++;
    if (bus.dma_busy) begin
      if (bus.mem_wen) begin
        if (bus.mem_addr == 16'h2004) wlog.push_back(bus.mem_wdata);
        else stray++;
        if (cnt[0] == 1'b0) par_bad++;
      end
      if (bus.mem_ren) begin
        rlog.push_back(bus.mem_addr);
        if (cnt[0] == 1'b1) par_bad++;
      end
      if (!bus.mem_wen && !bus.mem_ren) idle_busy++;
    end
    if (!b_rst) cnt = 0;
    else cnt = cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
    bus.cpu_addr_out = a;
    bus.cpu_data_out = d;
    bus.cpu_wen      = w;
    bus.cpu_ren      = r;
  endtask

  task automatic clear_logs();
    wlog.delete();
    rlog.delete();
    stall_cnt = 0;
    par_bad   = 0;
    stray     = 0;
    idle_busy = 0;
  endtask

  task automatic do_xfer(input logic [7:0] page, input bit odd, input bit noise,
                         input int abort_at, input string tag);
    logic [7:0] exp_b [256];
    logic [7:0] ram0;
    int exp_len, cyc, nerr, first_bad;
    bit done;
    @(negedge clk);
    drive(16'h0, 8'h0, 1'b0, 1'b0);
    if (cnt[0] != odd) @(negedge clk);
    clear_logs();
    ram0 = ram[16'h0000];
    drive(16'h4014, page, 1'b1, 1'b0);
    #1;
    chk({tag, " trig passthru"}, {15'd0, bus.mem_wen, bus.mem_addr}, {15'd0, 1'b1, 16'h4014});
    @(negedge clk);
    drive(16'h0, 8'h0, 1'b0, 1'b0);
    #1;
    chk({tag, " halt rdy"}, {31'd0, bus.cpu_rdy}, 32'd0);
    chk({tag, " halt busy"}, {31'd0, bus.dma_busy}, 32'd1);
    for (int i = 0; i < 256; i++) exp_b[i] = ram[{page, 8'(i)}];
    exp_len = odd ? 514 : 513;
    cyc  = 1;
    done = 0;
    for (int g = 0; g < 700 && !done; g++) begin
      @(negedge clk);
      if (abort_at > 0 && wlog.size() == abort_at) begin
        b_rst = 1'b0;
        @(negedge clk);
        b_rst = 1'b1;
        drive(16'h8000, 8'h0, 1'b0, 1'b1);
        #1;
        chk({tag, " abort busy"}, {31'd0, bus.dma_busy}, 32'd0);
        chk({tag, " abort rdy"}, {31'd0, bus.cpu_rdy}, 32'd1);
        chk({tag, " abort passthru"}, {15'd0, bus.mem_ren, bus.mem_addr}, {15'd0, 1'b1, 16'h8000});
        repeat (5) @(negedge clk);
        drive(16'h0, 8'h0, 1'b0, 1'b0);
        chk({tag, " abort no more writes"}, wlog.size(), abort_at);
        return;
      end
      cyc++;
      if (noise && cyc < exp_len - 2) begin
        case ($urandom_range(0, 3))
          0: drive(16'h4014, 8'h07, 1'b1, 1'b0);
          1: drive(16'h0000, 8'h55, 1'b1, 1'b0);
          2: drive(16'($urandom), 8'($urandom), 1'b0, 1'b1);
          default: drive(16'($urandom), 8'($urandom), 1'b1, 1'b0);
        endcase
      end else begin
        drive(16'h8000, 8'h0, 1'b0, 1'b1);
      end
      #1;
      if (bus.cpu_rdy) done = 1;
    end
    chk({tag, " finished in time"}, {31'd0, done}, 32'd1);
    chk({tag, " stall length"}, stall_cnt, exp_len);
    chk({tag, " end busy"}, {31'd0, bus.dma_busy}, 32'd0);
    chk({tag, " end passthru"}, {15'd0, bus.mem_ren, bus.mem_addr}, {15'd0, 1'b1, 16'h8000});
    chk({tag, " write count"}, wlog.size(), 256);
    chk({tag, " read count"}, rlog.size(), 256);
    nerr = 0;
    first_bad = -1;
    for (int i = 0; i < 256; i++) begin
      if (i >= wlog.size() || i >= rlog.size() || wlog[i] !== exp_b[i] ||
          rlog[i] !== {page, 8'(i)}) begin
        nerr++;
        if (first_bad < 0) first_bad = i;
      end
    end
    chk({tag, " data/addr order"}, nerr, 0);
    if (first_bad >= 0) $display("  first bad index %0d", first_bad);
    chk({tag, " parity"}, par_bad, 0);
    chk({tag, " stray writes"}, stray, 0);
    chk({tag, " idle bus cycles"}, idle_busy, odd ? 2 : 1);
    if (noise) chk({tag, " ram0 kept"}, {24'd0, ram[16'h0000]}, {24'd0, ram0});
    drive(16'h0, 8'h0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        w, r;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_wen, e_ren, e_busy;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{16'h8000, 8'h00, 1'b0, 1'b1, 16'h8000, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'h0010, 8'h3C, 1'b1, 1'b0, 16'h0010, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h4014, 8'h11, 1'b0, 1'b1, 16'h4014, 8'h11, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h1234, 8'hAB, 1'b0, 1'b0, 16'h1234, 8'hAB, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h4015, 8'h02, 1'b1, 1'b0, 16'h4015, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h4014, 8'h05, 1'b0, 1'b0, 16'h4014, 8'h05, 1'b0, 1'b0, 1'b0};

    b_rst = 1'b0;
    drive(16'h1234, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'(i) ^ 8'hA5;
    ram[16'h0000] = 8'h9C;
    clear_logs();
    repeat (3) @(negedge clk);
    #1;
    chk("reset rdy", {31'd0, bus.cpu_rdy}, 32'd1);
    chk("reset busy", {31'd0, bus.dma_busy}, 32'd0);
    chk("reset passthru", {15'd0, bus.mem_ren, bus.mem_addr}, {15'd0, 1'b1, 16'h1234});
    b_rst = 1'b1;

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(vecs[k].a, vecs[k].d, vecs[k].w, vecs[k].r);
      #1;
      chk($sformatf("vec%0d addr", k), {16'd0, bus.mem_addr}, {16'd0, vecs[k].e_addr});
      chk($sformatf("vec%0d wdata", k), {24'd0, bus.mem_wdata}, {24'd0, vecs[k].e_wdata});
      chk($sformatf("vec%0d wen/ren", k), {30'd0, bus.mem_wen, bus.mem_ren},
          {30'd0, vecs[k].e_wen, vecs[k].e_ren});
      @(negedge clk);
      drive(16'h0, 8'h0, 1'b0, 1'b0);
      #1;
      chk($sformatf("vec%0d busy after", k), {31'd0, bus.dma_busy}, {31'd0, vecs[k].e_busy});
    end
    chk("idle write landed", {24'd0, ram[16'h0010]}, 32'h3C);

    do_xfer(8'h02, 1'b0, 1'b0, 0, "even02");
    do_xfer(8'h02, 1'b1, 1'b0, 0, "odd02");
    do_xfer(8'h02, 1'b0, 1'b1, 0, "noise02");
    do_xfer(8'hFF, 1'b1, 1'b0, 0, "pageFF");
    do_xfer(8'h02, 1'b0, 1'b0, 100, "abort");
    do_xfer(8'h02, 1'b0, 1'b0, 0, "after_abort");

    // A trigger write coincident with a reset edge must be dropped.
    @(negedge clk);
    b_rst = 1'b0;
    drive(16'h4014, 8'h03, 1'b1, 1'b0);
    @(negedge clk);
    b_rst = 1'b1;
    drive(16'h0, 8'h0, 1'b0, 1'b0);
    #1;
    chk("rst+trig busy", {31'd0, bus.dma_busy}, 32'd0);
    @(negedge clk);
    #1;
    chk("rst+trig still idle", {31'd0, bus.cpu_rdy}, 32'd1);

    for (int n = 0; n < 4; n++)
      do_xfer(8'($urandom), 1'($urandom), 1'b1, 0, $sformatf("rand%0d", n));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sprite-RAM DMA sequencer for the CPU memory bus. It sits between the CPU core and the memory/IO map and watches for CPU writes to the SPR-RAM DMA register ($4014). When one occurs, it stalls the CPU and takes ownership of the bus. It then copies the 256-byte page $XX00–$XXFF into the SPR-RAM data register ($2004), one read/write pair per byte, and returns the bus to the CPU.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers a transfer.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
- XFER_LEN, 256, bytes per transfer. Fixed at 256: the source low byte is an 8-bit index.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- b_rst  in  1  reset, synchronous and active-low.
- cpu_addr_out  in  16  CPU address.
- cpu_data_out  in  8  CPU write data.
- cpu_wen  in  1  CPU write enable.
- cpu_ren  in  1  CPU read enable.
- cpu_rdy  out  1  1 = CPU may run; 0 = CPU stalled.
- dma_busy  out  1  1 while a transfer is in progress (any state other than IDLE).
- mem_addr  out  16  address to memory map.
- mem_wdata  out  8  write data to memory map.
- mem_wen  out  1  write enable to memory map.
- mem_ren  out  1  read enable to memory map.
- mem_rdata  in  8  combinational read data, valid in the same cycle as mem_ren.

## Operation
Bus mux:
- In IDLE, mem_* equal cpu_* (pass-through).
- In every other state, the DMA drives mem_*. CPU bus inputs are ignored.

Registers:
- state
- page_r[7:0]
- idx_r[7:0]
- data_r[7:0]
- parity_r: toggles every cycle; reset value 0. A cycle with parity_r==0 is "even".

States:
- IDLE
  - cpu_rdy=1.
  - Trigger condition: cpu_wen && cpu_addr_out==DMA_REG_ADDR.
  - On trigger: page_r<=cpu_data_out, idx_r<=0, next state HALT.
  - The triggering write still passes through to memory, so the $4014 register is updated.
- HALT
  - One cycle. Bus idle: mem_wen=mem_ren=0, mem_addr=0.
  - Next state is READ if parity_r==1 in this cycle, else ALIGN.
- ALIGN
  - One idle bus cycle; next state READ.
- READ
  - mem_addr={page_r,idx_r}, mem_ren=1.
  - data_r<=mem_rdata; next state WRITE.
- WRITE
  - mem_addr=OAM_DATA_ADDR, mem_wdata=data_r, mem_wen=1.
  - idx_r<=idx_r+1 (8-bit wrap).
  - Next state is IDLE if idx_r==8'hFF, else READ.
- dma_busy=1 and cpu_rdy=0 in HALT, ALIGN, READ and WRITE.
- Source address never leaves page_r: $XXFF is followed by the end of the transfer, not $(XX+1)00.
- Page $20–$3F is a legal source: IO reads are issued as-is. Page $00 is also legal.

## Timing
- Reset values: state=IDLE, parity_r=0, page_r=idx_r=data_r=0, cpu_rdy=1, dma_busy=0. mem_* follow the CPU pass-through.
- Trigger write in cycle T. HALT is in cycle T+1 and cpu_rdy falls to 0 in that same cycle.
- READ always lands on an even cycle and WRITE on an odd cycle.
- Stall length (cycles with cpu_rdy=0) is 513 if cycle T is even (parity_r==0), 514 if odd.
- The first read is issued in cycle T+2 (trigger even) or T+3 (trigger odd).
- The last WRITE (idx 8'hFF) is followed by IDLE in the next cycle. cpu_rdy=1 in that cycle, and the CPU's pending access passes through.
- While busy, CPU activity of any kind is ignored and never reaches memory, including writes to DMA_REG_ADDR (no retrigger).
- b_rst low in any cycle, mid-transfer included: at the next edge the block returns to the reset values. The partial transfer is abandoned with no further mem_wen.
- A trigger coincident with a reset edge is discarded.
- cpu_ren to DMA_REG_ADDR passes through in IDLE and never triggers.

## Test plan
- After reset, CPU writes $4014=8'h02 on an even cycle, with RAM $0200+i = i^8'hA5 -> cpu_rdy low for exactly 513 cycles, 256 writes to $2004 with data 8'hA5, 8'hA4, … in address order $0200..$02FF, then cpu_rdy=1.
- Same write issued on an odd cycle -> exactly 514 stall cycles, one ALIGN cycle with no mem_ren/mem_wen, and a first READ on an even cycle.
- During the transfer, CPU drives cpu_wen=1 to $4014 with 8'h07 and to $0000 with 8'h55 -> no retrigger, RAM[$0000] unchanged, page_r stays 8'h02.
- Source page 8'hFF (ROM $FF00–$FFFF) -> last read at $FFFF, no access to $0000, idx wraps and the block returns to IDLE.
- b_rst asserted after the 100th WRITE -> next cycle IDLE, cpu_rdy=1, dma_busy=0, no further $2004 writes. A new $4014 write then performs a full transfer from idx 0.
- Idle pass-through: CPU read of $8000 and write to $0010=8'h3C -> mem_* match cpu_* in the same cycle, and dma_busy stays 0.
